// File: rtl/ins_memory_loader_pkg.sv
// Shared loader definitions: FSM state encodings and default widths used by Full_System.
package ins_memory_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_START = 2'd2,
        LDR_ERROR = 2'd3
    } ldr_state_e;

    localparam int LDR_REG_WIDTH = 12;
    localparam int LDR_IM_WIDTH  = 8;

endpackage

// File: rtl/ins_memory_loader_word_checksum.sv
// Running modulo-2**reg_width sum of written program words, cleared at the start of each load.
module ins_memory_loader_word_checksum #(
    parameter int reg_width = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 accumulate_i,
    input  logic [reg_width-1:0] word_i,
    output logic [reg_width-1:0] result_o
);

    logic [reg_width-1:0] sum_q;
    logic [reg_width-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (accumulate_i) begin
            sum_d = sum_q + word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign result_o = sum_q;

endmodule

// File: rtl/ins_memory_loader.sv
// Streams program words into Ins_Memory from address 0 and pulses start after a good load.
// Optional LOADER_CHECKSUM_EN: the last beat carries a checksum and is verified, not written.
module ins_memory_loader
    import ins_memory_loader_pkg::*;
#(
    parameter int reg_width  = LDR_REG_WIDTH,
    parameter int Im_width   = LDR_IM_WIDTH,
    parameter int prog_words = 2 ** Im_width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_req,
    input  logic [reg_width-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [Im_width-1:0]  im_address,
    output logic [reg_width-1:0] im_data,
    output logic                 im_wren,
    output logic                 start,
    output logic                 busy,
    output logic                 load_err,
    output logic [Im_width:0]    word_count
);

    localparam logic [Im_width:0] LAST_IDX = (Im_width + 1)'(prog_words - 1);

    ldr_state_e           state_q;
    logic                 in_ready_q;
    logic [Im_width-1:0]  im_address_q;
    logic [reg_width-1:0] im_data_q;
    logic                 im_wren_q;
    logic                 start_q;
    logic                 busy_q;
    logic                 load_err_q;
    logic [Im_width:0]    word_count_q;

    logic beat_acc;
    logic write_beat;
    logic at_limit;
    logic load_entry;
    logic ck_ok;

    assign beat_acc   = in_valid && in_ready_q;
    assign at_limit   = (word_count_q == LAST_IDX);
    assign load_entry = load_req && ((state_q == LDR_IDLE) || (state_q == LDR_ERROR));

`ifdef LOADER_CHECKSUM_EN
    logic [reg_width-1:0] csum;

    // The checksum beat itself is excluded from both the memory write and the sum.
    ins_memory_loader_word_checksum #(
        .reg_width (reg_width)
    ) u_word_checksum (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (load_entry),
        .accumulate_i (beat_acc && !in_last),
        .word_i       (in_data),
        .result_o     (csum)
    );

    assign write_beat = beat_acc && !in_last;
    assign ck_ok      = (in_data == csum);
`else
    assign write_beat = beat_acc;
    assign ck_ok      = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LDR_IDLE;
            in_ready_q   <= 1'b0;
            im_address_q <= '0;
            im_data_q    <= '0;
            im_wren_q    <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            im_wren_q <= 1'b0;
            start_q   <= 1'b0;
            case (state_q)
                LDR_IDLE, LDR_ERROR: begin
                    if (load_req) begin
                        state_q      <= LDR_LOAD;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        load_err_q   <= 1'b0;
                        word_count_q <= '0;
                    end
                end
                LDR_LOAD: begin
                    if (write_beat) begin
                        im_wren_q    <= 1'b1;
                        im_address_q <= word_count_q[Im_width-1:0];
                        im_data_q    <= in_data;
                        word_count_q <= word_count_q + 1'b1;
                    end
                    // Overflow stops at the last legal address, so the address never wraps.
                    if (beat_acc) begin
                        if (in_last && ck_ok) begin
                            state_q    <= LDR_START;
                            in_ready_q <= 1'b0;
                        end else if (in_last || at_limit) begin
                            state_q    <= LDR_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                LDR_START: begin
                    start_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= LDR_IDLE;
                end
                default: begin
                    state_q    <= LDR_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign im_address = im_address_q;
    assign im_data    = im_data_q;
    assign im_wren    = im_wren_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule
